// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define BCD_SIGNED_EN to treat bin_in as two's complement and report neg.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     acc_adj;
  logic [WIDTH-1:0]  load_val;
  logic              capture;

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

`ifdef BCD_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic load_sign;
  logic sign_q, sign_d;
  logic neg_q, neg_d;

  always_comb begin
    load_sign = bin_in[WIDTH-1];
    load_val  = load_sign ? (~bin_in + ONE) : bin_in;
  end

  always_comb begin
    sign_d = sign_q;
    neg_d  = neg_q;
    if (state_q == DONE)
      neg_d = sign_q;
    if (capture)
      sign_d = load_sign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      neg_q  <= neg_d;
    end
  end

  assign neg = neg_q;
`else
  assign load_val = bin_in;
  assign neg      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          capture = 1'b1;
      end
      SHIFT: begin
        busy_d = 1'b1;
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE)
          state_d = DONE;
      end
      DONE: begin
        bcd_d  = acc_q;
        done_d = 1'b1;
        if (start)
          capture = 1'b1;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      sr_d    = load_val;
      acc_d   = '0;
      cnt_d   = CNT_INIT;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector and sweep bench for bin2bcd_seq.
// Signed vectors are used when BCD_SIGNED_EN is defined.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic        neg;

  int nchecks = 0;
  int nerrs   = 0;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .neg     (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [19:0] bcd;
    logic        sgn;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [20:0] model(input logic [13:0] v);
    logic [13:0] mag;
    logic        s;
    logic [19:0] r;
    int          m;
    mag = v;
    s   = 1'b0;
`ifdef BCD_SIGNED_EN
    if (v[13]) begin
      mag = ~v + 14'd1;
      s   = 1'b1;
    end
`endif
    m = int'(mag);
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {s, r};
  endfunction

  // Starts one conversion from IDLE and waits (bounded) for done
  task automatic run_conv(input logic [13:0] v, output logic [19:0] b,
                          output logic n, output int lat, output int bn);
    bin_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat = 0;
    bn  = 0;
    while (lat < 40) begin
      step();
      lat++;
      if (busy) bn++;
      if (done) break;
    end
    b = bcd_out;
    n = neg;
  endtask

  vec_t        vecs[7];
  logic [19:0] b;
  logic        n;
  int          lat;
  int          bn;
  int          dcnt;
  logic [20:0] exp_v;
  logic [13:0] v;

  initial begin
`ifdef BCD_SIGNED_EN
    vecs[0] = '{14'd0,    20'h00000, 1'b0};
    vecs[1] = '{14'h3FFF, 20'h00001, 1'b1};
    vecs[2] = '{14'h2000, 20'h08192, 1'b1};
    vecs[3] = '{14'd100,  20'h00100, 1'b0};
    vecs[4] = '{14'h1FFF, 20'h08191, 1'b0};
    vecs[5] = '{14'h3F9C, 20'h00100, 1'b1};
    vecs[6] = '{14'd1,    20'h00001, 1'b0};
`else
    vecs[0] = '{14'd0,     20'h00000, 1'b0};
    vecs[1] = '{14'd16383, 20'h16383, 1'b0};
    vecs[2] = '{14'd9999,  20'h09999, 1'b0};
    vecs[3] = '{14'd1,     20'h00001, 1'b0};
    vecs[4] = '{14'd8192,  20'h08192, 1'b0};
    vecs[5] = '{14'd1000,  20'h01000, 1'b0};
    vecs[6] = '{14'd10,    20'h00010, 1'b0};
`endif

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].bin, b, n, lat, bn);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd15);
      check($sformatf("vec%0d_busy", i), 32'(bn), 32'd14);
      check($sformatf("vec%0d_bcd", i), 32'(b), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].sgn));
      step();
      check($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
    end

    // start while busy is ignored; start held in DONE chains a new conversion
    dcnt   = 0;
    bin_in = 14'd1234;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      step();
      if (done) dcnt++;
      if (e == 5) begin
        start  = 1'b1;
        bin_in = 14'd42;
      end
      if (e == 6) start = 1'b0;
      if (e == 14) begin
        start  = 1'b1;
        bin_in = 14'd42;
      end
      if (e == 15) begin
        start = 1'b0;
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_bcd1", 32'(bcd_out), 32'h01234);
      end
      if (e == 16) check("b2b_busy2", 32'(busy), 32'd1);
      if (e == 29) check("b2b_hold", 32'(bcd_out), 32'h01234);
      if (e == 30) begin
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_bcd2", 32'(bcd_out), 32'h00042);
      end
    end
    check("b2b_count", 32'(dcnt), 32'd2);

    // reset mid-conversion abandons the result
    dcnt   = 0;
    bin_in = 14'd500;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (done) dcnt++;
      if (e == 6) rst = 1'b1;
      if (e == 7) begin
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_bcd", 32'(bcd_out), 32'd0);
      end
    end
    check("rst_mid_nodone", 32'(dcnt), 32'd0);
    run_conv(14'd77, b, n, lat, bn);
    check("post_rst_lat", 32'(lat), 32'd15);
    check("post_rst_bcd", 32'(b), 32'h00077);
    step();

    // reference-model sweep over corners and random values
    for (int i = 0; i < 1600; i++) begin
      if (i < 64) v = 14'(i);
      else if (i < 128) v = 14'(16383 - (i - 64));
      else v = 14'($urandom_range(0, 16383));
      exp_v = model(v);
      run_conv(v, b, n, lat, bn);
      check($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd15);
      check($sformatf("sweep_bcd_%0d", v), 32'(b), 32'(exp_v[19:0]));
      check($sformatf("sweep_neg_%0d", v), 32'(n), 32'(exp_v[20]));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
